// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory signal bundle
//   master (controller) inputs : op_code, func (IR fields), mem_ready, br_cond, syscall_exit
//   master (controller) outputs: mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
//                                alu_src_b, alu_op, signed_ext, reg_write, reg_dst, mem_to_reg,
//                                sys_pulse, halted, err, err_code, instr_cnt
//   slave is the datapath/memory view with directions reversed
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op_code;
    logic [5:0]       func;
    logic             mem_ready;
    logic             br_cond;
    logic             syscall_exit;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             signed_ext;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             sys_pulse;
    logic             halted;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op_code, func, mem_ready, br_cond, syscall_exit,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, signed_ext, reg_write, reg_dst, mem_to_reg, sys_pulse, halted,
               err, err_code, instr_cnt
    );

    modport slave (
        output op_code, func, mem_ready, br_cond, syscall_exit,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, signed_ext, reg_write, reg_dst, mem_to_reg, sys_pulse, halted,
               err, err_code, instr_cnt
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: sequenced multi-cycle MIPS controller
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_control_if.master (IR fields, memory handshake, datapath strobes,
//           halt/error status, retired-instruction counter)
module multicycle_control #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int SYSCALL_HALT = 1,
    parameter int CNT_W        = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_SLT = 4'd4, ALU_SLTU = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8, ALU_NOR = 4'd9, ALU_LUI = 4'd10;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT, S_ERROR
    } state_t;

    state_t           r_state, w_next;
    logic [5:0]       r_op, r_func;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wait_st, w_tmo;

    function automatic state_t f_route(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                                      6'h00, 6'h02, 6'h03, 6'h07, 6'h0C}) ? S_EXEC_R :
                          (fn == 6'h08) ? S_JUMP : S_ERROR;
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return S_EXEC_I;
            6'h23, 6'h24, 6'h2B: return S_MEM_ADDR;
            6'h04, 6'h05, 6'h06: return S_BRANCH;
            6'h02, 6'h03: return S_JUMP;
            default: return S_ERROR;
        endcase
    endfunction

    function automatic logic [3:0] f_ralu(input logic [5:0] fn);
        case (fn)
            6'h22:        return ALU_SUB;
            6'h24:        return ALU_AND;
            6'h25:        return ALU_OR;
            6'h27:        return ALU_NOR;
            6'h2A:        return ALU_SLT;
            6'h2B:        return ALU_SLTU;
            6'h00:        return ALU_SLL;
            6'h02:        return ALU_SRL;
            6'h03, 6'h07: return ALU_SRA;
            default:      return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] f_ialu(input logic [5:0] op);
        case (op)
            6'h0A:   return ALU_SLT;
            6'h0C:   return ALU_AND;
            6'h0D:   return ALU_OR;
            6'h0F:   return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    assign w_wait_st = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    // Fires on the last allowed wait cycle; a ready on that cycle still completes.
    assign w_tmo     = (MEM_TIMEOUT > 0) && !bus.mem_ready && (r_wait == WW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_op       <= '0;
            r_func     <= '0;
            r_wait     <= '0;
            r_err_code <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op   <= bus.op_code;
                r_func <= bus.func;
            end
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_wait_st && !bus.mem_ready)
                r_wait <= r_wait + 1'b1;
            if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_INIT)
                r_cnt <= r_cnt + 1'b1;
            if (w_next == S_ERROR && r_state != S_ERROR)
                r_err_code <= (r_state == S_DECODE) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = ALU_ADD;
        bus.signed_ext = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 2'd0;
        bus.sys_pulse  = 1'b0;
        bus.halted     = r_state == S_HALT;
        bus.err        = r_state == S_ERROR;
        case (r_state)
            S_INIT: w_next = S_FETCH;
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                w_next        = bus.mem_ready ? S_DECODE : w_tmo ? S_ERROR : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_b  = 2'd3;
                bus.signed_ext = 1'b1;
                w_next         = f_route(bus.op_code, bus.func);
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = f_ralu(r_func);
                bus.sys_pulse = r_func == 6'h0C;
                w_next        = (r_func != 6'h0C) ? S_WB_ALU :
                                (SYSCALL_HALT != 0 && bus.syscall_exit) ? S_HALT : S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'd2;
                bus.alu_op     = f_ialu(r_op);
                bus.signed_ext = !(r_op inside {6'h0C, 6'h0D, 6'h0F});
                w_next         = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'd2;
                bus.signed_ext = 1'b1;
                w_next         = (r_op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = r_state == S_MEM_WR;
                w_next      = bus.mem_ready ? ((r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH) :
                              w_tmo ? S_ERROR : r_state;
            end
            S_WB_ALU: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (r_op == 6'h00) ? 2'd1 : 2'd0;
                w_next        = S_FETCH;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (r_op == 6'h24) ? 2'd2 : 2'd1;
                w_next         = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_write  = bus.br_cond;
                bus.pc_src    = 2'd1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = (r_op == 6'h00) ? 2'd3 : 2'd2;
                bus.reg_write  = r_op == 6'h03;
                bus.reg_dst    = (r_op == 6'h03) ? 2'd2 : 2'd0;
                bus.mem_to_reg = (r_op == 6'h03) ? 2'd3 : 2'd0;
                w_next         = S_FETCH;
            end
            S_HALT, S_ERROR: w_next = r_state;
            default: w_next = S_INIT;
        endcase
    end

    assign bus.err_code  = r_err_code;
    assign bus.instr_cnt = r_cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.MEM_TIMEOUT(4), .SYSCALL_HALT(1), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] outs();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.signed_ext, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.sys_pulse, bus.halted, bus.err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        bus.op_code = '0; bus.func = '0; bus.mem_ready = 1'b0;
        bus.br_cond = 1'b0; bus.syscall_exit = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // From a FETCH cycle: fetch op/fn with zero wait, land in the first post-DECODE state.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn);
        bus.mem_ready = 1'b1;
        bus.op_code = op;
        bus.func = fn;
        cyc();
        cyc();
        #1;
    endtask

    initial begin
        bus.op_code = '0; bus.func = '0; bus.mem_ready = 1'b0;
        bus.br_cond = 1'b0; bus.syscall_exit = 1'b0;
        #3;
        check("rst_outs", 32'(outs()), 0);
        do_reset();
        check("init_outs", 32'(outs()), 0);
        check("init_cnt", bus.instr_cnt, 0);
        check("init_errc", 32'(bus.err_code), 0);

        // ADD $3,$1,$2
        bus.mem_ready = 1'b1;
        cyc();
        check("fetch_strb", {bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src}, 6'b101100);
        check("fetch_alu", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 7'b0010000);
        bus.op_code = 6'h00; bus.func = 6'h20;
        cyc();
        check("dec_alu", {bus.mem_req, bus.alu_src_a, bus.alu_src_b, bus.signed_ext}, 5'b00111);
        cyc();
        bus.op_code = 6'h3F; bus.func = 6'h3F;
        #1;
        check("add_exec", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 7'b1000000);
        cyc();
        check("add_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 5'b10100);
        check("add_cnt0", bus.instr_cnt, 0);
        cyc();
        check("add_cnt1", bus.instr_cnt, 1);

        // LBU with three wait cycles, ready on the 4th (last allowed) cycle
        issue(6'h24, 6'h00);
        check("lbu_addr", {bus.alu_src_a, bus.alu_src_b, bus.signed_ext, bus.alu_op}, 8'b11010000);
        bus.mem_ready = 1'b0;
        cyc();
        check("lbu_rd", {bus.mem_req, bus.mem_we, bus.iord}, 3'b101);
        cyc();
        cyc();
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        check("lbu_rd4", {bus.mem_req, bus.err, bus.reg_write}, 3'b100);
        cyc();
        check("lbu_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 5'b10010);
        cyc();
        check("lbu_cnt", bus.instr_cnt, 2);

        // BEQ not taken, then taken
        bus.br_cond = 1'b0;
        issue(6'h04, 6'h00);
        check("beq0", {bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 10'b0011000001);
        cyc();
        check("beq0_cnt", bus.instr_cnt, 3);
        bus.br_cond = 1'b1;
        issue(6'h04, 6'h00);
        check("beq1", {bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 10'b1011000001);
        cyc();
        check("beq1_cnt", bus.instr_cnt, 4);

        // JAL
        issue(6'h03, 6'h00);
        check("jal", {bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 8'b11011011);
        cyc();
        check("jal_cnt", bus.instr_cnt, 5);

        // SW
        issue(6'h2B, 6'h00);
        cyc();
        check("sw_wr", {bus.mem_req, bus.mem_we, bus.iord, bus.reg_write}, 4'b1110);
        cyc();
        check("sw_cnt", bus.instr_cnt, 6);

        // JR
        issue(6'h00, 6'h08);
        check("jr", {bus.pc_write, bus.pc_src, bus.reg_write}, 4'b1110);
        cyc();

        // ANDI: zero-extended immediate, writes rt
        issue(6'h0C, 6'h00);
        check("andi_ex", {bus.alu_src_a, bus.alu_src_b, bus.signed_ext, bus.alu_op}, 8'b11000010);
        cyc();
        check("andi_wb", {bus.reg_write, bus.reg_dst}, 3'b100);
        cyc();
        check("andi_cnt", bus.instr_cnt, 8);

        // SYSCALL without exit retires
        bus.syscall_exit = 1'b0;
        issue(6'h00, 6'h0C);
        check("sys", {bus.sys_pulse, bus.reg_write, bus.halted}, 3'b100);
        cyc();
        check("sys_cnt", bus.instr_cnt, 9);

        // Timeout: ready stuck low in FETCH
        bus.mem_ready = 1'b0;
        #1;
        cyc();
        cyc();
        cyc();
        check("tmo_c4", {bus.mem_req, bus.err}, 2'b10);
        cyc();
        check("tmo_err", {bus.err, bus.err_code, bus.mem_req, bus.halted}, 5'b10100);
        bus.mem_ready = 1'b1;
        cyc();
        check("err_hold", {bus.err, bus.err_code, bus.mem_req, bus.ir_write}, 5'b10100);
        check("err_cnt", bus.instr_cnt, 9);

        // Illegal opcode
        do_reset();
        check("rst_errc", {bus.err, bus.err_code}, 3'b000);
        bus.mem_ready = 1'b1;
        cyc();
        issue(6'h3F, 6'h00);
        check("illegal", {bus.err, bus.err_code, bus.mem_req, bus.pc_write}, 5'b11000);

        // SYSCALL with exit halts
        do_reset();
        bus.mem_ready = 1'b1;
        cyc();
        bus.syscall_exit = 1'b1;
        issue(6'h00, 6'h0C);
        check("sysh_pulse", bus.sys_pulse, 1);
        cyc();
        check("halt", {bus.halted, bus.err, bus.mem_req, bus.sys_pulse}, 4'b1000);
        cyc();
        check("halt_hold", {bus.halted, bus.pc_write, bus.ir_write}, 3'b100);
        check("halt_cnt", bus.instr_cnt, 0);

        // Asynchronous reset in the middle of a store
        do_reset();
        bus.mem_ready = 1'b1;
        cyc();
        issue(6'h2B, 6'h00);
        bus.mem_ready = 1'b0;
        cyc();
        check("mw_req", {bus.mem_req, bus.mem_we}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(outs()), 0);
        check("rst_async_cnt", bus.instr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
